serial_frame_rx: RTL and testbench

Serial frame receiver that sits directly downstream of the enabled sampling flip-flop (`top_v`). It consumes that stage's registered bit stream, qualified by the same enable. It recovers framed serial words (start bit, data bits LSB-first, optional even parity, stop bit) and presents each word on a parallel port behind a one-entry holding register with a valid/ready handshake. It also reports framing/parity errors and overflow.

---
 rtl/serial_frame_rx.sv | 100 ++++++++++
 tb/tb_serial_frame_rx.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: recovers start/data/parity/stop framed words from a qualified bit stream
// and presents them behind a one-entry valid/ready holding register.
module serial_frame_rx #(
  parameter int DATA_W    = 8,
  parameter int PARITY_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              d,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              frame_err,
  output logic              overflow,
  output logic              busy
);
  localparam int CW = DATA_W > 1 ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic              par_q, par_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dv_q, dv_d;
  logic              ferr_q, ferr_d;
  logic              ovf_q, ovf_d;
  logic              stop_ev, good, accept, load;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    par_d   = par_q;
    stop_ev = 1'b0;
    if (en) begin
      case (state_q)
        IDLE: begin
          state_d = d ? DATA : IDLE;
          cnt_d   = '0;
        end
        DATA: begin
          sh_d[cnt_q] = d;
          state_d     = cnt_q == LAST ? (PARITY_EN != 0 ? PARITY : STOP) : DATA;
          cnt_d       = cnt_q == LAST ? '0 : cnt_q + 1'b1;
        end
        PARITY: begin
          par_d   = d;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          stop_ev = 1'b1;
        end
      endcase
    end
  end

  // every data bit is rewritten each frame, so the shift register needs no clear between frames
  assign good   = stop_ev && !d && (PARITY_EN == 0 || !(^sh_q ^ par_q));
  assign accept = dv_q && data_ready;
  assign load   = good && (!dv_q || accept);
  assign dv_d   = load ? 1'b1 : (accept ? 1'b0 : dv_q);
  assign dout_d = load ? sh_q : dout_q;
  assign ferr_d = stop_ev && !good;
  assign ovf_d  = ovf_q || (good && !load);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      ferr_q  <= ferr_d;
      ovf_q   <= ovf_d;
    end
  end

  assign data_out   = dout_q;
  assign data_valid = dv_q;
  assign frame_err  = ferr_q;
  assign overflow   = ovf_q;
  assign busy       = state_q != IDLE;
endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx: directed and randomized frames against a frame-level reference model.
module tb_serial_frame_rx;
  logic       clk = 1'b0;
  logic       rst, en, d, data_ready;
  logic [7:0] data_out;
  logic       data_valid, frame_err, overflow, busy;
  int         checks = 0, errors = 0;
  bit         m_valid = 0, m_ovf = 0, m_ferr = 0;
  logic [7:0] m_data = 8'h00;
  int         busy_low;

  serial_frame_rx #(.DATA_W(8), .PARITY_EN(1)) dut (
    .clk(clk), .rst(rst), .en(en), .d(d), .data_out(data_out), .data_valid(data_valid),
    .data_ready(data_ready), .frame_err(frame_err), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  // one clock edge; the model applies frame completion and handshake at word level
  task automatic tick(input bit stop_now, input bit good, input logic [7:0] w);
    bit acc;
    acc = m_valid && data_ready;
    @(posedge clk);
    #1;
    if (rst) begin
      m_valid = 0; m_ovf = 0; m_ferr = 0; m_data = 8'h00;
    end else begin
      m_ferr = stop_now && !good;
      if (stop_now && good && (!m_valid || acc)) begin
        m_valid = 1; m_data = w;
      end else begin
        if (stop_now && good) m_ovf = 1;
        if (acc) m_valid = 0;
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] w, input bit p, input bit s, input bit gap,
                            input bit rdy_rand, input bit rdy_stop);
    logic [10:0] bits;
    bit good;
    bits = {s, p, w, 1'b1};
    good = !s && !(^w ^ p);
    busy_low = 0;
    for (int i = 0; i < 11; i++) begin
      if (gap) begin
        en = 0; d = 1'($urandom);
        if (rdy_rand) data_ready = 1'($urandom);
        tick(0, 0, 8'h00);
        if (i > 0 && !busy) busy_low++;
      end
      en = 1; d = bits[i];
      if (rdy_rand) data_ready = 1'($urandom);
      if (i == 10 && rdy_stop) data_ready = 1;
      tick(i == 10, good, w);
      if (i < 10 && !busy) busy_low++;
    end
    en = 0; d = 0;
    if (rdy_rand || rdy_stop) data_ready = 0;
  endtask

  task automatic drain();
    data_ready = 1; tick(0, 0, 8'h00); data_ready = 0;
  endtask

  task automatic test_reset();
    rst = 1; en = 1; d = 1; data_ready = 0;
    for (int i = 0; i < 2; i++) begin
      tick(0, 0, 8'h00);
      checks++;
      if ({data_out, data_valid, frame_err, overflow, busy} !== 12'h000) begin
        errors++; $display("FAIL reset_outputs got %h exp 000", {data_out, data_valid, frame_err, overflow, busy});
      end
    end
    rst = 0;
    send_frame(8'h5A, 0, 0, 0, 0, 0);
    checks++;
    if (busy_low !== 0) begin errors++; $display("FAIL first_start busy_low got %0d exp 0", busy_low); end
    checks++;
    if ({data_valid, data_out} !== {1'b1, 8'h5A}) begin
      errors++; $display("FAIL first_frame got %b/%h exp 1/5a", data_valid, data_out);
    end
    drain();
    en = 1; d = 1; tick(0, 0, 8'h00);
    d = 0; for (int i = 0; i < 3; i++) tick(0, 0, 8'h00);
    rst = 1; en = 0; tick(0, 0, 8'h00);
    checks++;
    if ({busy, frame_err, data_valid} !== 3'b000) begin
      errors++; $display("FAIL midframe_reset got %b exp 000", {busy, frame_err, data_valid});
    end
    rst = 0;
    send_frame(8'h3C, 0, 0, 0, 0, 0);
    checks++;
    if ({data_valid, data_out, frame_err} !== {1'b1, 8'h3C, 1'b0}) begin
      errors++; $display("FAIL after_abort got %b/%h/%b exp 1/3c/0", data_valid, data_out, frame_err);
    end
    drain();
  endtask

  task automatic test_good();
    send_frame(8'hA5, 0, 0, 0, 0, 0);
    checks++;
    if ({data_valid, data_out} !== {1'b1, 8'hA5}) begin
      errors++; $display("FAIL good_frame got %b/%h exp 1/a5", data_valid, data_out);
    end
    checks++;
    if (frame_err !== 1'b0) begin errors++; $display("FAIL good_ferr got %b exp 0", frame_err); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL good_busy_fall got %b exp 0", busy); end
    drain();
  endtask

  task automatic test_gapped();
    send_frame(8'hA5, 0, 0, 1, 0, 0);
    checks++;
    if ({data_valid, data_out} !== {1'b1, 8'hA5}) begin
      errors++; $display("FAIL gapped_frame got %b/%h exp 1/a5", data_valid, data_out);
    end
    checks++;
    if (busy_low !== 0) begin errors++; $display("FAIL gapped_busy low_cycles got %0d exp 0", busy_low); end
    drain();
  endtask

  task automatic test_errors();
    send_frame(8'h01, 0, 0, 0, 0, 0);
    checks++;
    if ({frame_err, data_valid} !== 2'b10) begin
      errors++; $display("FAIL parity_err got %b exp 10", {frame_err, data_valid});
    end
    tick(0, 0, 8'h00);
    checks++;
    if (frame_err !== 1'b0) begin errors++; $display("FAIL parity_err_pulse got %b exp 0", frame_err); end
    send_frame(8'h03, 0, 1, 0, 0, 0);
    checks++;
    if ({frame_err, data_valid} !== 2'b10) begin
      errors++; $display("FAIL stop_err got %b exp 10", {frame_err, data_valid});
    end
    tick(0, 0, 8'h00);
    checks++;
    if ({frame_err, data_valid} !== 2'b00) begin
      errors++; $display("FAIL stop_err_pulse got %b exp 00", {frame_err, data_valid});
    end
  endtask

  task automatic test_overflow();
    data_ready = 0;
    send_frame(8'h11, 0, 0, 0, 0, 0);
    send_frame(8'h22, 0, 0, 0, 0, 0);
    checks++;
    if ({data_valid, data_out, overflow} !== {1'b1, 8'h11, 1'b1}) begin
      errors++; $display("FAIL overflow_hold got %b/%h/%b exp 1/11/1", data_valid, data_out, overflow);
    end
    drain();
    checks++;
    if ({data_valid, overflow} !== 2'b01) begin
      errors++; $display("FAIL overflow_drain got %b exp 01", {data_valid, overflow});
    end
  endtask

  task automatic test_simul();
    rst = 1; tick(0, 0, 8'h00); rst = 0;
    send_frame(8'h33, 0, 0, 0, 0, 0);
    checks++;
    if ({data_valid, data_out} !== {1'b1, 8'h33}) begin
      errors++; $display("FAIL simul_first got %b/%h exp 1/33", data_valid, data_out);
    end
    send_frame(8'h44, 0, 0, 0, 0, 1);
    checks++;
    if ({data_valid, data_out, overflow} !== {1'b1, 8'h44, 1'b0}) begin
      errors++; $display("FAIL simul_load got %b/%h/%b exp 1/44/0", data_valid, data_out, overflow);
    end
  endtask

  task automatic test_random();
    logic [7:0] w;
    bit p, s;
    for (int n = 0; n < 40; n++) begin
      w = 8'($urandom);
      p = ($urandom_range(3) == 0) ? ~^w : ^w;
      s = ($urandom_range(4) == 0);
      send_frame(w, p, s, 1'($urandom), 1, 0);
      checks++;
      if ({data_valid, data_out, frame_err, overflow, busy} !== {m_valid, m_data, m_ferr, m_ovf, 1'b0}) begin
        errors++;
        $display("FAIL random_frame %0d got v=%b d=%h fe=%b ov=%b bz=%b exp v=%b d=%h fe=%b ov=%b bz=0",
                 n, data_valid, data_out, frame_err, overflow, busy, m_valid, m_data, m_ferr, m_ovf);
      end
    end
  endtask

  initial begin
    rst = 0; en = 0; d = 0; data_ready = 0;
    test_reset();
    test_good();
    test_gapped();
    test_errors();
    test_overflow();
    test_simul();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
